// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination lock controller: display message codes,
// controller states and small nibble/selector helpers.
package combo_lock_pkg;

   localparam logic [2:0] SEL_LOCK = 3'b000;
   localparam logic [2:0] SEL_D1   = 3'b001;
   localparam logic [2:0] SEL_D2   = 3'b010;
   localparam logic [2:0] SEL_D3   = 3'b011;
   localparam logic [2:0] SEL_D4   = 3'b100;
   localparam logic [2:0] SEL_DASH = 3'b101;
   localparam logic [2:0] SEL_PASS = 3'b110;
   localparam logic [2:0] SEL_FAIL = 3'b111;

   typedef enum logic [2:0] {
      LOCKED  = 3'd0,
      ENTRY   = 3'd1,
      CHECK   = 3'd2,
      OPEN    = 3'd3,
      FAIL    = 3'd4,
      LOCKOUT = 3'd5
   } state_e;

   // Digit index 0 is the leftmost digit, stored in the top nibble.
   function automatic logic [15:0] put_nibble(input logic [15:0] word,
                                              input logic [1:0]  idx,
                                              input logic [3:0]  val);
      logic [15:0] w;
      w = word;
      case (idx)
         2'd0:    w[15:12] = val;
         2'd1:    w[11:8]  = val;
         2'd2:    w[7:4]   = val;
         default: w[3:0]   = val;
      endcase
      return w;
   endfunction

   function automatic logic [2:0] sel_code(input state_e st, input logic [1:0] idx);
      logic [2:0] s;
      case (st)
         LOCKED:  s = SEL_LOCK;
         ENTRY:   s = SEL_D1 + {1'b0, idx};
         CHECK:   s = SEL_DASH;
         OPEN:    s = SEL_PASS;
         FAIL:    s = SEL_FAIL;
         LOCKOUT: s = SEL_DASH;
         default: s = SEL_LOCK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/combo_lock_ctrl_btn_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, stable-level counter and a
// one-cycle pulse on each accepted press (release is accepted silently).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic btn_raw,
   output logic btn_pulse
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised input disagrees with the
   // accepted level, so any bounce back restarts the qualification window.
   always_comb begin
      level_d = level_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            pulse_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_pulse = pulse_q;

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock controller: debounced buttons drive digit entry, code compare,
// fail hold and lockout; emits the Number/Selector pair for the display driver.
module combo_lock_ctrl #(
   parameter logic [15:0] SECRET          = 16'h1234,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned HOLD_CYCLES     = 200000000,
   parameter int unsigned LOCKOUT_CYCLES  = 1000000000,
   parameter int unsigned MAX_FAILS       = 3
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Btn_Up,
   input  logic       Btn_Down,
   input  logic       Btn_Enter,
   output logic [3:0] Number,
   output logic [2:0] Selector,
   output logic       Unlocked,
   output logic       Lockout
);

   import combo_lock_pkg::*;

   localparam int unsigned TMR_MAX = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int unsigned FCNT_W  = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1;

   localparam logic [TMR_W-1:0]  HOLD_LOAD    = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FCNT_W-1:0] FAIL_LIMIT   = FCNT_W'(MAX_FAILS);

   logic up_p, down_p, enter_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .Clock     (Clock),
      .Reset     (Reset),
      .btn_raw   (Btn_Up),
      .btn_pulse (up_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .Clock     (Clock),
      .Reset     (Reset),
      .btn_raw   (Btn_Down),
      .btn_pulse (down_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
      .Clock     (Clock),
      .Reset     (Reset),
      .btn_raw   (Btn_Enter),
      .btn_pulse (enter_p)
   );

   state_e            state_q, state_d;
   logic [1:0]        digit_q, digit_d;
   logic [3:0]        num_q, num_d;
   logic [15:0]       entry_q, entry_d;
   logic [FCNT_W-1:0] fails_q, fails_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [2:0]        sel_q;
   logic              unl_q, lck_q;

   // Pulses are consumed only where the current state listens; elsewhere they
   // fall through the default hold and are lost by design.
   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      num_d   = num_q;
      entry_d = entry_q;
      fails_d = fails_q;
      tmr_d   = tmr_q;
      case (state_q)
         LOCKED: begin
            if (enter_p) begin
               state_d = ENTRY;
               digit_d = 2'd0;
               num_d   = 4'd0;
            end
         end
         ENTRY: begin
            if (enter_p) begin
               entry_d = put_nibble(entry_q, digit_q, num_q);
               num_d   = 4'd0;
               if (digit_q == 2'd3) begin
                  state_d = CHECK;
               end else begin
                  digit_d = digit_q + 2'd1;
               end
            end else if (up_p && !down_p) begin
               num_d = num_q + 4'd1;
            end else if (down_p && !up_p) begin
               num_d = num_q - 4'd1;
            end
         end
         CHECK: begin
            if (entry_q == SECRET) begin
               state_d = OPEN;
               fails_d = '0;
            end else begin
               state_d = FAIL;
               tmr_d   = HOLD_LOAD;
               fails_d = (fails_q == FAIL_LIMIT) ? fails_q : fails_q + FCNT_W'(1);
            end
         end
         OPEN: begin
            if (enter_p) begin
               state_d = LOCKED;
               entry_d = 16'h0000;
            end
         end
         FAIL: begin
            if (tmr_q == '0) begin
               if (fails_q == FAIL_LIMIT) begin
                  state_d = LOCKOUT;
                  tmr_d   = LOCKOUT_LOAD;
               end else begin
                  state_d = LOCKED;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         LOCKOUT: begin
            if (tmr_q == '0) begin
               state_d = LOCKED;
               fails_d = '0;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = LOCKED;
         end
      endcase
   end

   // Outputs are registered from next-state so they change on the same edge as the state.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= LOCKED;
         digit_q <= 2'd0;
         num_q   <= 4'd0;
         entry_q <= 16'h0000;
         fails_q <= '0;
         tmr_q   <= '0;
         sel_q   <= SEL_LOCK;
         unl_q   <= 1'b0;
         lck_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         digit_q <= digit_d;
         num_q   <= num_d;
         entry_q <= entry_d;
         fails_q <= fails_d;
         tmr_q   <= tmr_d;
         sel_q   <= sel_code(state_d, digit_d);
         unl_q   <= (state_d == OPEN);
         lck_q   <= (state_d == LOCKOUT);
      end
   end

   assign Number   = num_q;
   assign Selector = sel_q;
   assign Unlocked = unl_q;
   assign Lockout  = lck_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Bench for combo_lock_ctrl: a behavioural lock model checked every cycle, plus
// literal expectations at key points of each scenario.
module tb_combo_lock_ctrl;

   localparam int D    = 4;
   localparam int H    = 16;
   localparam int L    = 32;
   localparam int MAXF = 3;
   localparam logic [15:0] SECRET = 16'h1234;

   localparam int B_UP = 0;
   localparam int B_DN = 1;
   localparam int B_EN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       b_up = 1'b0, b_dn = 1'b0, b_en = 1'b0;
   logic [3:0] number;
   logic [2:0] selector;
   logic       unlocked, lockout;

   int  checks = 0;
   int  passes = 0;
   bit  started = 0;

   always #5 clk = ~clk;

   combo_lock_ctrl #(
      .SECRET          (SECRET),
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .LOCKOUT_CYCLES  (L),
      .MAX_FAILS       (MAXF)
   ) dut (
      .Clock     (clk),
      .Reset     (rst),
      .Btn_Up    (b_up),
      .Btn_Down  (b_dn),
      .Btn_Enter (b_en),
      .Number    (number),
      .Selector  (selector),
      .Unlocked  (unlocked),
      .Lockout   (lockout)
   );

   // ---------------- behavioural model ----------------
   typedef enum int {M_LOCKED, M_ENTRY, M_CHECK, M_OPEN, M_FAIL, M_LOCKOUT} mode_t;

   mode_t m_mode;
   int    m_idx, m_num, m_fails, m_left;
   int    m_code[4];
   bit    raw_h[3][D+2];
   bit    lvl[3];
   bit    pend[3];

   function automatic bit raw_of(input int b);
      case (b)
         B_UP:    return b_up;
         B_DN:    return b_dn;
         default: return b_en;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = M_LOCKED;
      m_idx = 1; m_num = 0; m_fails = 0; m_left = 0;
      for (int k = 0; k < 4; k++) m_code[k] = 0;
      for (int b = 0; b < 3; b++) begin
         lvl[b] = 0;
         pend[b] = 0;
         for (int j = 0; j < D + 2; j++) raw_h[b][j] = 0;
      end
   endtask

   task automatic model_fsm(input bit pu, input bit pd, input bit pe);
      bit ok;
      case (m_mode)
         M_LOCKED: if (pe) begin m_mode = M_ENTRY; m_idx = 1; m_num = 0; end
         M_ENTRY: begin
            if (pe) begin
               m_code[m_idx - 1] = m_num;
               m_num = 0;
               if (m_idx == 4) m_mode = M_CHECK;
               else m_idx = m_idx + 1;
            end else if (pu && !pd) m_num = (m_num + 1) % 16;
            else if (pd && !pu) m_num = (m_num + 15) % 16;
         end
         M_CHECK: begin
            ok = 1;
            for (int k = 0; k < 4; k++)
               if (m_code[k] != int'((SECRET >> (4 * (3 - k))) & 16'hF)) ok = 0;
            if (ok) begin m_mode = M_OPEN; m_fails = 0; end
            else begin
               m_mode = M_FAIL;
               m_left = H;
               m_fails = (m_fails + 1 > MAXF) ? MAXF : m_fails + 1;
            end
         end
         M_OPEN: if (pe) begin
            m_mode = M_LOCKED;
            for (int k = 0; k < 4; k++) m_code[k] = 0;
         end
         M_FAIL: begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               if (m_fails == MAXF) begin m_mode = M_LOCKOUT; m_left = L; end
               else m_mode = M_LOCKED;
            end
         end
         default: begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_mode = M_LOCKED; m_fails = 0; end
         end
      endcase
   endtask

   // A press is accepted when the last D synchronised samples (raw delayed two
   // cycles) agree on a level different from the accepted one.
   initial begin
      bit same;
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else begin
            model_fsm(pend[B_UP], pend[B_DN], pend[B_EN]);
            for (int b = 0; b < 3; b++) begin
               for (int j = D + 1; j > 0; j--) raw_h[b][j] = raw_h[b][j-1];
               raw_h[b][0] = raw_of(b);
               same = 1;
               for (int j = 2; j <= D + 1; j++) if (raw_h[b][j] != raw_h[b][2]) same = 0;
               pend[b] = 0;
               if (same && raw_h[b][2] != lvl[b]) begin
                  lvl[b] = raw_h[b][2];
                  pend[b] = lvl[b];
               end
            end
         end
      end
   end

   function automatic logic [2:0] exp_sel();
      case (m_mode)
         M_LOCKED: return 3'b000;
         M_ENTRY:  return 3'(m_idx);
         M_OPEN:   return 3'b110;
         M_FAIL:   return 3'b111;
         default:  return 3'b101;
      endcase
   endfunction

   // ---------------- scoreboard / run-length monitor ----------------
   int run_f = 0, run_l = 0, run_d = 0;
   int last_f = 0, last_l = 0, last_d = 0;

   initial begin
      logic [3:0] e_num;
      logic [2:0] e_sel;
      logic       e_unl, e_lck;
      wait (started);
      forever begin
         @(negedge clk);
         e_num = (m_mode == M_ENTRY) ? 4'(m_num) : 4'd0;
         e_sel = exp_sel();
         e_unl = (m_mode == M_OPEN);
         e_lck = (m_mode == M_LOCKOUT);
         checks++;
         if ({number, selector, unlocked, lockout} === {e_num, e_sel, e_unl, e_lck}) passes++;
         else $display("FAIL cycle_compare t=%0t: got num=%h sel=%b unl=%b lck=%b, expected num=%h sel=%b unl=%b lck=%b",
                       $time, number, selector, unlocked, lockout, e_num, e_sel, e_unl, e_lck);
         if (rst) begin
            run_f = 0; run_l = 0; run_d = 0;
         end else begin
            if (selector == 3'b111) run_f++;
            else if (run_f != 0) begin last_f = run_f; run_f = 0; end
            if (lockout === 1'b1) run_l++;
            else if (run_l != 0) begin last_l = run_l; run_l = 0; end
            if (selector == 3'b101 && lockout === 1'b0) run_d++;
            else if (run_d != 0) begin last_d = run_d; run_d = 0; end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_lit(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_btn(input int b, input bit v);
      case (b)
         B_UP:    b_up = v;
         B_DN:    b_dn = v;
         default: b_en = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      cycles(D + 4);
      set_btn(b, 1'b0);
      cycles(D + 4);
   endtask

   task automatic enter_code(input logic [15:0] c);
      int d;
      press(B_EN);
      for (int k = 0; k < 4; k++) begin
         d = int'((c >> (12 - 4 * k)) & 16'hF);
         repeat (d) press(B_UP);
         press(B_EN);
      end
   endtask

   // ---------------- directed scenarios ----------------
   int bt[8] = '{2, 1, 3, 2, 1, 3, 1, 2};

   initial begin
      #1 rst = 1'b1;
      started = 1;
      repeat (3) @(negedge clk);
      check_lit("reset_number", number, 0);
      check_lit("reset_selector", selector, 0);
      check_lit("reset_unlocked", unlocked, 0);
      check_lit("reset_lockout", lockout, 0);
      @(posedge clk); #2 rst = 1'b0;
      cycles(2);

      // Bounce on Up inside ENTRY(1)
      press(B_EN);
      @(negedge clk);
      check_lit("entry1_selector", selector, 1);
      for (int i = 0; i < 8; i++) begin
         b_up = (i % 2 == 0);
         cycles(bt[i]);
      end
      b_up = 1'b1;
      cycles(10);
      @(negedge clk);
      check_lit("bounce_number", number, 1);
      b_up = 1'b0;
      cycles(D + 4);
      @(negedge clk);
      check_lit("bounce_release_number", number, 1);

      // Finish the correct code 1-2-3-4
      press(B_EN);
      @(negedge clk); check_lit("entry2_selector", selector, 2);
      repeat (2) press(B_UP);
      press(B_EN);
      @(negedge clk); check_lit("entry3_selector", selector, 3);
      repeat (3) press(B_UP);
      press(B_EN);
      @(negedge clk); check_lit("entry4_selector", selector, 4);
      repeat (4) press(B_UP);
      press(B_EN);
      @(negedge clk);
      check_lit("open_selector", selector, 6);
      check_lit("open_unlocked", unlocked, 1);
      check_lit("check_dash_cycles", last_d, 1);
      press(B_UP);
      @(negedge clk);
      check_lit("open_up_ignored_number", number, 0);
      check_lit("open_up_ignored_selector", selector, 6);
      press(B_EN);
      @(negedge clk);
      check_lit("relock_selector", selector, 0);
      check_lit("relock_unlocked", unlocked, 0);

      // Wrap-around in ENTRY(1)
      press(B_EN);
      press(B_DN);
      @(negedge clk); check_lit("wrap_down_number", number, 15);
      press(B_UP);
      @(negedge clk); check_lit("wrap_up_number", number, 0);
      repeat (16) press(B_UP);
      @(negedge clk); check_lit("wrap_up16_number", number, 0);

      // Wrong code 0000, with Up and Enter pressed during the hold
      repeat (3) press(B_EN);
      b_en = 1'b1;
      cycles(D + 4);
      @(negedge clk); check_lit("fail_selector", selector, 7);
      #1 b_en = 1'b0;
      b_up = 1'b1;
      cycles(4);
      b_en = 1'b1;
      cycles(8);
      b_en = 1'b0;
      b_up = 1'b0;
      cycles(20);
      @(negedge clk);
      check_lit("fail_hold_cycles", last_f, 16);
      check_lit("after_fail_selector", selector, 0);
      check_lit("after_fail_number", number, 0);

      // Two more failures reach lockout
      enter_code(16'h0000);
      cycles(25);
      @(negedge clk); check_lit("second_fail_selector", selector, 0);
      enter_code(16'h5678);
      cycles(20);
      @(negedge clk);
      check_lit("lockout_flag", lockout, 1);
      check_lit("lockout_selector", selector, 5);
      cycles(40);
      @(negedge clk);
      check_lit("lockout_cycles", last_l, 32);
      check_lit("after_lockout_selector", selector, 0);
      check_lit("after_lockout_flag", lockout, 0);
      enter_code(SECRET);
      @(negedge clk);
      check_lit("post_lockout_open", selector, 6);
      check_lit("post_lockout_unlocked", unlocked, 1);
      press(B_EN);

      // Asynchronous reset in ENTRY(3)
      press(B_EN);
      press(B_UP); press(B_EN);
      repeat (2) press(B_UP);
      press(B_EN);
      repeat (7) press(B_UP);
      @(negedge clk);
      check_lit("pre_reset_selector", selector, 3);
      check_lit("pre_reset_number", number, 7);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_lit("async_reset_number", number, 0);
      check_lit("async_reset_selector", selector, 0);
      check_lit("async_reset_unlocked", unlocked, 0);
      check_lit("async_reset_lockout", lockout, 0);
      cycles(3);
      rst = 1'b0;
      cycles(2);
      press(B_EN);
      @(negedge clk); check_lit("restart_selector", selector, 1);
      press(B_EN);
      @(negedge clk); check_lit("restart_digit2_selector", selector, 2);
      press(B_UP);
      @(negedge clk); check_lit("restart_digit2_number", number, 1);
      press(B_EN);
      repeat (3) press(B_UP);
      press(B_EN);
      repeat (4) press(B_UP);
      press(B_EN);
      @(negedge clk);
      check_lit("restart_wrong_fail", selector, 7);
      cycles(25);
      enter_code(SECRET);
      @(negedge clk);
      check_lit("restart_open", selector, 6);
      cycles(3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Input-side controller for the combination lock. It takes raw Basys 3 pushbuttons, debounces them, and runs the entry and compare state machine. It drives the Number/Selector pair consumed by the four-digit seven-segment display driver. It is the producer of the Selector code protocol that the display decodes.

Parameters:
SECRET, 16'h1234, unlock code; nibble [15:12] is digit 1 (leftmost, AN3) through [3:0] is digit 4 (AN0)
DEBOUNCE_CYCLES, 1000000, stable-level time before a press is accepted (10 ms at 100 MHz)
HOLD_CYCLES, 200000000, FAIL message display time (2 s)
LOCKOUT_CYCLES, 1000000000, lockout duration after MAX_FAILS failures (10 s)
MAX_FAILS, 3, consecutive failures that trigger lockout

Ports:
Clock  in  1  100 MHz system clock
Reset  in  1  asynchronous, active-high; all state returns to reset values immediately
Btn_Up  in  1  raw pushbutton, increments current digit
Btn_Down  in  1  raw pushbutton, decrements current digit
Btn_Enter  in  1  raw pushbutton, start/commit/relock
Number  out  4  digit value shown at the active entry position
Selector  out  3  display message code: 000 LOCK, 001-100 entry digit 1-4, 101 dashes, 110 PASS, 111 FAIL
Unlocked  out  1  high only in OPEN
Lockout  out  1  high only in LOCKOUT

Behaviour:
- One clock (Clock); reset is asynchronous, active-high (Reset). All outputs are registered.
- Reset values: Number=0, Selector=3'b000, Unlocked=0, Lockout=0, fail count=0, entry register=0, state=LOCKED.
- Each button uses a 2-flop synchroniser and a counter. The level is accepted once the synchronised input holds a new value for DEBOUNCE_CYCLES consecutive cycles. A single-cycle pulse is emitted on each accepted 0->1 transition. Release emits no pulse.
- Press latency: pulse appears 2+DEBOUNCE_CYCLES cycles after a clean edge. FSM outputs update on the cycle after the pulse.
- Same-cycle pulses: Enter has priority and Up/Down are dropped. Up together with Down (no Enter) is a no-op.
- Pulses in states that ignore buttons are discarded, never queued.
- States and transitions:
  LOCKED: Selector=000. Enter -> ENTRY with digit index 1, Number=0.
  ENTRY(k), k=1..4: Selector=k (001..100).
    - Up: Number+1 mod 16 (F->0).
    - Down: Number-1 mod 16 (0->F).
    - Enter: store Number into nibble k of the entry register, then Number=0. If k<4, go to ENTRY(k+1); if k=4, go to CHECK.
  CHECK: Selector=101 for exactly 1 cycle. Compare entry register with SECRET.
    - Equal -> OPEN, fail count cleared.
    - Not equal -> FAIL, fail count+1 (saturates at MAX_FAILS).
  OPEN: Selector=110, Unlocked=1. Enter -> LOCKED, entry register cleared. Up/Down ignored.
  FAIL: Selector=111 for HOLD_CYCLES cycles; buttons ignored. When the hold expires, go to LOCKOUT if fail count==MAX_FAILS, else LOCKED.
  LOCKOUT: Selector=101, Lockout=1 for LOCKOUT_CYCLES cycles; buttons ignored. On expiry go to LOCKED with fail count=0.
- Number is 0 in every state except ENTRY.
- A single shared timer serves FAIL and LOCKOUT. It is sized to clog2(max(HOLD_CYCLES, LOCKOUT_CYCLES)), loaded on state entry, and counts down; the state exits on the cycle the timer reaches 0.
- Reset asserted mid-entry, mid-hold or mid-lockout aborts immediately. It clears the fail count and the partial code.

Decomposition:
- Shared package combo_lock_pkg holds:
  - Selector code constants: SEL_LOCK=3'b000, SEL_D1..SEL_D4=3'b001..3'b100, SEL_DASH=3'b101, SEL_PASS=3'b110, SEL_FAIL=3'b111.
  - State enum: LOCKED, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports Clock, Reset, btn_raw, btn_pulse), instantiated three times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, LOCKOUT_CYCLES=32, SECRET=16'h1234.
- Bounce: toggle Btn_Up at 1-3 cycle intervals, then hold high for 10 cycles while in ENTRY(1) -> exactly one increment, Number=1; release produces no change.
- Correct code: Enter, Up x1 + Enter, Up x2 + Enter, Up x3 + Enter, Up x4 + Enter -> Selector steps 001,010,011,100; 101 for 1 cycle; then 110 with Unlocked=1. A further Enter -> Selector=000, Unlocked=0.
- Wrap-around: in ENTRY(1), Down once -> Number=F; Up once -> Number=0; Up x16 -> Number=0.
- Wrong code 0000 -> Selector=111 for 16 cycles, then 000, fail count=1; Up/Enter pulses during the hold have no effect.
- Three consecutive wrong codes -> after the third FAIL hold, Selector=101 and Lockout=1 for 32 cycles, then Selector=000. Correct code afterward reaches OPEN.
- Reset asserted asynchronously in ENTRY(3) with Number=7 -> outputs are reset values within the same cycle, with no clock edge needed. Enter + Enter + Up x1 + Enter... must re-enter the full code from digit 1.
